// File: rtl/cv_dma_loader.sv
`default_nettype none
// ============================================================================
// Module   : cv_dma_loader
// Brief    : Memory-side data mover that feeds (load) and drains (store) one
//            CV engine over a shared request/grant memory port.
// Revision : 1.0 - initial release
// ============================================================================
module cv_dma_loader #(
    parameter int ADDR_W          = 32,
    parameter int LEN_W           = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_store,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [15:0]       mem_rdata,
    output logic              din_valid,
    output logic [15:0]       din_data,
    input  logic              dout_valid,
    output logic              dout_ready,
    input  logic [15:0]       dout_data
);

    localparam int                 c_OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [c_OUT_W-1:0] c_MAX_OUT = c_OUT_W'(MAX_OUTSTANDING);
    localparam logic [c_OUT_W-1:0] c_OUT_ONE = c_OUT_W'(1);
    localparam logic [LEN_W-1:0]   c_LEN_ONE = LEN_W'(1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_LOAD   = 2'd1;
    localparam logic [1:0] c_STORE  = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_issued;
    logic [LEN_W-1:0]   r_received;
    logic [LEN_W-1:0]   r_captured;
    logic [LEN_W-1:0]   r_written;
    logic [c_OUT_W-1:0] r_outstanding;
    logic [15:0]        r_wbuf;
    logic               r_wfull;
    logic               r_din_valid;
    logic [15:0]        r_din_data;
    logic               w_accept;
    logic               w_xfer;
    logic               w_capture;
    logic               w_rvalid;

    assign w_accept  = (r_state == c_IDLE) && cmd_valid;
    assign w_xfer    = mem_req && mem_gnt;
    assign w_capture = dout_valid && dout_ready;
    // Returns are only meaningful inside a load; stale ones after an abort are dropped.
    assign w_rvalid  = (r_state == c_LOAD) && mem_rvalid;

    assign din_valid = r_din_valid;
    assign din_data  = r_din_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_len == '0)   w_next_state = c_FINISH;
                    else if (cmd_store)  w_next_state = c_STORE;
                    else                 w_next_state = c_LOAD;
                end
            end
            c_LOAD:   if (r_received == r_len) w_next_state = c_FINISH;
            c_STORE:  if (r_written == r_len)  w_next_state = c_FINISH;
            default:  w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = (r_state == c_IDLE);
        busy       = (r_state != c_IDLE);
        done       = (r_state == c_FINISH);
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        dout_ready = 1'b0;
        case (r_state)
            c_LOAD: begin
                mem_req  = (r_issued < r_len) && (r_outstanding < c_MAX_OUT);
                mem_addr = r_addr + ADDR_W'(r_issued);
            end
            c_STORE: begin
                mem_req    = r_wfull;
                mem_we     = 1'b1;
                mem_addr   = r_addr + ADDR_W'(r_written);
                mem_wdata  = r_wbuf;
                // A buffer being drained this cycle can take the next word at once.
                dout_ready = (r_captured < r_len) && (!r_wfull || (r_wfull && mem_gnt));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_received    <= '0;
            r_captured    <= '0;
            r_written     <= '0;
            r_outstanding <= '0;
            r_wbuf        <= '0;
            r_wfull       <= 1'b0;
            r_din_valid   <= 1'b0;
            r_din_data    <= '0;
        end else begin
            r_din_valid <= w_rvalid;
            if (w_rvalid) r_din_data <= mem_rdata;

            if (w_accept) begin
                r_addr        <= cmd_addr;
                r_len         <= cmd_len;
                r_issued      <= '0;
                r_received    <= '0;
                r_captured    <= '0;
                r_written     <= '0;
                r_outstanding <= '0;
                r_wfull       <= 1'b0;
            end

            if (r_state == c_LOAD) begin
                if (w_xfer)   r_issued   <= r_issued + c_LEN_ONE;
                if (w_rvalid) r_received <= r_received + c_LEN_ONE;
                case ({w_xfer, w_rvalid})
                    2'b10:   r_outstanding <= r_outstanding + c_OUT_ONE;
                    2'b01:   r_outstanding <= r_outstanding - c_OUT_ONE;
                    default: ;
                endcase
            end

            if (r_state == c_STORE) begin
                if (w_capture) begin
                    r_wbuf     <= dout_data;
                    r_captured <= r_captured + c_LEN_ONE;
                end
                if (w_xfer) r_written <= r_written + c_LEN_ONE;
                r_wfull <= w_capture || (r_wfull && !w_xfer);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cv_dma_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv_dma_loader
// Brief    : Randomized self-checking bench for cv_dma_loader with a
//            transaction-level reference model and memory/engine responders.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cv_dma_loader;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_store;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        busy, done;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        din_valid, dout_valid, dout_ready;
    logic [15:0] din_data, dout_data;

    always #5 clk = ~clk;

    cv_dma_loader #(
        .ADDR_W          (32),
        .LEN_W           (16),
        .MAX_OUTSTANDING (MAX_OUT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_store  (cmd_store),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .din_valid  (din_valid),
        .din_data   (din_data),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_data  (dout_data)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_t;

    // Memory and engine responders
    rd_t         rd_q[$];
    logic [15:0] rdata_tbl[$];
    logic [15:0] eng_q[$];
    int          gnt_mode = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          last_due = 0;
    bit          dv_always = 1'b1;

    // Transaction-level model of the command in progress
    bit          m_busy = 1'b0;
    bit          m_store = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_len, m_issued, m_outst, m_received, m_captured, m_written;
    int          m_done_at = -1;
    logic [15:0] m_words[$];
    bit          exp_dv = 1'b0;
    logic [15:0] exp_dd = '0;

    // Observation logs for hand-computed expectations
    logic [31:0] rd_addr_log[$];
    logic [31:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    logic [15:0] din_log[$];
    int          last_din_cyc, done_cyc, acc_cyc, done_cnt, max_out;

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, want);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic want);
        chk_w(name, {31'd0, act}, {31'd0, want});
    endtask

    task automatic clear_logs();
        rd_addr_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); din_log.delete();
        last_din_cyc = -1; done_cyc = -1; acc_cyc = -1; done_cnt = 0; max_out = 0;
    endtask

    task automatic drive_env();
        case (gnt_mode)
            0:       mem_gnt = 1'b1;
            1:       mem_gnt = (cyc % 2 == 1);
            default: mem_gnt = ($urandom_range(0, 1) == 1);
        endcase
        if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rd_q[0].data;
            void'(rd_q.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
        end
        dout_valid = (eng_q.size() > 0) && (dv_always || $urandom_range(0, 1) == 1);
        dout_data  = (eng_q.size() > 0) ? eng_q[0] : 16'h0;
    endtask

    task automatic check_update();
        bit          e_req, e_we, e_dr, e_done, acc, xfer, cap;
        logic [31:0] e_addr;
        logic [15:0] e_wd, nd;
        int          d;
        e_req = 0; e_we = 0; e_dr = 0; e_addr = '0; e_wd = '0;
        if (m_busy && !m_store) begin
            e_req  = (m_issued < m_len) && (m_outst < MAX_OUT);
            e_addr = m_addr + 32'(m_issued);
        end else if (m_busy) begin
            e_req  = (m_captured > m_written);
            e_we   = 1'b1;
            e_addr = m_addr + 32'(m_written);
            if (e_req) e_wd = m_words[m_written];
            e_dr   = (m_captured < m_len) && (!e_req || mem_gnt);
        end
        e_done = (cyc == m_done_at);

        if (chk_en) begin
            chk_b("busy", busy, m_busy);
            chk_b("cmd_ready", cmd_ready, !m_busy);
            chk_b("done", done, e_done);
            chk_b("mem_req", mem_req, e_req);
            chk_b("dout_ready", dout_ready, e_dr);
            chk_b("din_valid", din_valid, exp_dv);
            if (exp_dv) chk_w("din_data", 32'(din_data), 32'(exp_dd));
            if (e_req) begin
                chk_b("mem_we", mem_we, e_we);
                chk_w("mem_addr", mem_addr, e_addr);
                if (e_we) chk_w("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            end
        end

        xfer = e_req && mem_gnt;
        cap  = e_dr && dout_valid;
        acc  = !m_busy && cmd_valid;

        // Responders react to what the DUT actually did.
        if (mem_req && mem_gnt && !mem_we) begin
            d = cyc + $urandom_range(lat_min, lat_max);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            nd = (rdata_tbl.size() > 0) ? rdata_tbl.pop_front() : 16'($urandom);
            rd_q.push_back('{d, nd});
            rd_addr_log.push_back(mem_addr);
            if (rd_q.size() > max_out) max_out = rd_q.size();
        end
        if (mem_req && mem_gnt && mem_we) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
        end
        if (dout_valid && dout_ready && eng_q.size() > 0) void'(eng_q.pop_front());
        if (din_valid) begin din_log.push_back(din_data); last_din_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (cmd_valid && cmd_ready) acc_cyc = cyc;

        if (rst) begin
            m_busy = 0; m_done_at = -1; exp_dv = 0;
        end else begin
            exp_dv = m_busy && !m_store && mem_rvalid;
            exp_dd = mem_rdata;
            if (m_busy && !m_store) begin
                if (xfer) begin m_issued++; m_outst++; end
                if (mem_rvalid) begin
                    m_outst--; m_received++;
                    if (m_received == m_len) m_done_at = cyc + 2;
                end
            end else if (m_busy) begin
                if (cap) begin m_words.push_back(dout_data); m_captured++; end
                if (xfer) begin
                    m_written++;
                    if (m_written == m_len) m_done_at = cyc + 2;
                end
            end
            if (e_done) m_busy = 0;
            if (acc) begin
                m_busy = 1; m_store = cmd_store; m_addr = cmd_addr; m_len = int'(cmd_len);
                m_issued = 0; m_outst = 0; m_received = 0; m_captured = 0; m_written = 0;
                m_words.delete();
                if (cmd_len == 16'd0) m_done_at = cyc + 1;
            end
        end
    endtask

    task automatic cycle();
        drive_env();
        #3;
        check_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_cmd(input bit st, input logic [31:0] a, input int len);
        cmd_valid = 1'b1; cmd_store = st; cmd_addr = a; cmd_len = 16'(len);
        cycle();
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_len = 16'($urandom);
        for (int k = 0; k < 3000 && m_busy; k++) cycle();
        if (m_busy) begin
            n_vec++; n_err++;
            $display("FAIL cmd_timeout @cycle %0d: got busy=1, want completion", cyc);
            m_busy = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] t1_data[3];
        logic [15:0] t2_data[8];
        bit          st;
        int          len;
        logic [31:0] a;

        rst = 1'b1; cmd_valid = 0; cmd_store = 0; cmd_addr = '0; cmd_len = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; dout_valid = 0; dout_data = '0;
        clear_logs();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk_b("rst_cmd_ready", cmd_ready, 1'b1);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_b("rst_mem_req", mem_req, 1'b0);
        chk_b("rst_mem_we", mem_we, 1'b0);
        chk_w("rst_mem_addr", mem_addr, 32'h0);
        chk_w("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk_b("rst_din_valid", din_valid, 1'b0);
        chk_w("rst_din_data", 32'(din_data), 32'h0);
        chk_b("rst_dout_ready", dout_ready, 1'b0);
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Load 3 words, 2-cycle read latency
        t1_data = '{16'h00A1, 16'h00A2, 16'h00A3};
        clear_logs(); gnt_mode = 0; lat_min = 2; lat_max = 2;
        for (int i = 0; i < 3; i++) rdata_tbl.push_back(t1_data[i]);
        run_cmd(1'b0, 32'h100, 3);
        chk_w("t1_nreads", rd_addr_log.size(), 3);
        chk_w("t1_ndin", din_log.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < rd_addr_log.size()) chk_w("t1_raddr", rd_addr_log[i], 32'h100 + 32'(i));
            if (i < din_log.size())     chk_w("t1_din", 32'(din_log[i]), 32'(t1_data[i]));
        end
        chk_w("t1_done_lat", done_cyc - last_din_cyc, 1);
        chk_w("t1_ndone", done_cnt, 1);
        chk_b("t1_busy_after", busy, 1'b0);

        // Load 8 words with long latency to hit the outstanding limit
        t2_data = '{16'hB0, 16'hB1, 16'hB2, 16'hB3, 16'hB4, 16'hB5, 16'hB6, 16'hB7};
        clear_logs(); lat_min = 10; lat_max = 10;
        for (int i = 0; i < 8; i++) rdata_tbl.push_back(t2_data[i]);
        run_cmd(1'b0, 32'h200, 8);
        chk_w("t2_max_out", max_out, MAX_OUT);
        chk_w("t2_ndin", din_log.size(), 8);
        for (int i = 0; i < 8 && i < din_log.size(); i++)
            chk_w("t2_din", 32'(din_log[i]), 32'(t2_data[i]));

        // Store 4 words, alternating grant, engine offers a 5th
        clear_logs(); gnt_mode = 1; dv_always = 1;
        for (int i = 0; i < 5; i++) eng_q.push_back(16'h11 + 16'(i));
        run_cmd(1'b1, 32'h20, 4);
        chk_w("t3_nwrites", wr_addr_log.size(), 4);
        for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
            chk_w("t3_waddr", wr_addr_log[i], 32'h20 + 32'(i));
            chk_w("t3_wdata", 32'(wr_data_log[i]), 32'h11 + 32'(i));
        end
        chk_w("t3_left_in_engine", eng_q.size(), 1);
        chk_w("t3_ndone", done_cnt, 1);
        eng_q.delete();

        // Zero-length commands in both modes
        clear_logs(); gnt_mode = 0; lat_min = 1; lat_max = 3;
        run_cmd(1'b0, 32'h40, 0);
        chk_w("t4_load_done_lat", done_cyc - acc_cyc, 1);
        eng_q.push_back(16'h5555); eng_q.push_back(16'h6666);
        run_cmd(1'b1, 32'h40, 0);
        chk_w("t4_store_done_lat", done_cyc - acc_cyc, 1);
        chk_w("t4_engine_untouched", eng_q.size(), 2);
        chk_w("t4_no_traffic", rd_addr_log.size() + wr_addr_log.size() + din_log.size(), 0);
        eng_q.delete();

        // Reset mid-load with reads in flight
        clear_logs(); lat_min = 10; lat_max = 10;
        cmd_valid = 1; cmd_store = 0; cmd_addr = 32'h300; cmd_len = 16'd8;
        cycle();
        cmd_valid = 0;
        for (int k = 0; k < 50 && m_outst < 2; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        din_log.delete();
        repeat (20) cycle();
        chk_w("t5_late_din", din_log.size(), 0);
        chk_b("t5_cmd_ready", cmd_ready, 1'b1);
        chk_b("t5_mem_req", mem_req, 1'b0);
        chk_w("t5_drained", rd_q.size(), 0);

        // Address wrap
        clear_logs(); lat_min = 1; lat_max = 3;
        run_cmd(1'b0, 32'hFFFF_FFFF, 2);
        chk_w("t6_nreads", rd_addr_log.size(), 2);
        if (rd_addr_log.size() == 2) begin
            chk_w("t6_addr0", rd_addr_log[0], 32'hFFFF_FFFF);
            chk_w("t6_addr1", rd_addr_log[1], 32'h0000_0000);
        end

        // Randomized back-to-back traffic
        for (int n = 0; n < 30; n++) begin
            st  = ($urandom_range(0, 1) == 1);
            len = $urandom_range(0, 12);
            a   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            gnt_mode  = $urandom_range(0, 2);
            lat_min   = 1;
            lat_max   = $urandom_range(1, 6);
            dv_always = ($urandom_range(0, 1) == 1);
            if (st) for (int i = 0; i < len + int'($urandom_range(0, 2)); i++) eng_q.push_back(16'($urandom));
            run_cmd(st, a, len);
            eng_q.delete();
            repeat ($urandom_range(0, 2)) cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cv_dma_loader.md
Name: cv_dma_loader

Overview:
- Memory-side data mover that feeds and drains one CV engine.
- Load command: reads a contiguous run of 16-bit words from the shared memory port and pushes them onto the engine's din_valid/din_data stream.
- Store command: pulls words from the engine's dout_valid/dout_ready stream and writes them to a contiguous memory run.
- Sits between the top-level controller / memory arbiter and the CV engine. The controller pulses load_weight/load_input/store_output on the engine in step with commands issued here.

Parameters:
- ADDR_W, 32, memory word-address width.
- LEN_W, 16, command length width, in words.
- MAX_OUTSTANDING, 4, maximum granted reads not yet returned (power of two, ≥ 1).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when high together with cmd_valid; high only in IDLE.
- cmd_store  input  1  0 = load (memory→engine), 1 = store (engine→memory).
- cmd_addr  input  ADDR_W  start word address.
- cmd_len  input  LEN_W  number of words.
- busy  output  1  high whenever the block is not in IDLE.
- done  output  1  one-cycle pulse when a command completes.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  ADDR_W  request address.
- mem_wdata  output  16  write data.
- mem_gnt  input  1  request accepted this cycle (mem_req & mem_gnt = transfer).
- mem_rvalid  input  1  read data returning, in request order, at least 1 cycle after grant.
- mem_rdata  input  16  read data.
- din_valid  output  1  to engine; the engine has no backpressure.
- din_data  output  16  to engine.
- dout_valid  input  1  from engine.
- dout_ready  output  1  to engine.
- dout_data  input  16  from engine.

Behaviour:
- Reset values: cmd_ready=1, busy=0, done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, din_valid=0, din_data=0, dout_ready=0. All counters are cleared.
- Reset mid-command aborts immediately; in-flight mem_rvalid returns after reset are ignored.
- States: IDLE, LOAD, STORE, FINISH.
- IDLE → LOAD or STORE on cmd_valid & cmd_ready. The command fields are latched on acceptance.
- cmd_len = 0: IDLE → FINISH directly, with no memory traffic.
- LOAD:
  - mem_req = 1, mem_we = 0, while issued < len and outstanding < MAX_OUTSTANDING.
  - mem_addr = addr + issued. The address wraps modulo 2^ADDR_W.
  - Each grant increments issued and outstanding.
  - Each mem_rvalid decrements outstanding and increments received.
  - A grant and an rvalid in the same cycle leave outstanding unchanged.
  - din_valid/din_data are registered copies of mem_rvalid/mem_rdata: exactly 1 cycle latency, no buffering, no stalls.
  - Once received == len: go to FINISH.
- STORE:
  - One-entry write buffer (wbuf, wfull).
  - dout_ready = 1 when (captured < len) and (!wfull or (mem_req & mem_gnt)).
  - A dout_valid & dout_ready transfer loads wbuf and sets wfull.
  - mem_req = wfull, mem_we = 1, mem_wdata = wbuf, mem_addr = addr + written.
  - A grant increments written and clears wfull, unless a new word is captured in the same cycle; in that case wfull stays 1.
  - Once written == len: go to FINISH.
- Extra words: dout words beyond len are not accepted, because dout_ready stays low.
- FINISH: done = 1 for exactly one cycle, busy = 1, then return to IDLE.
- Back-to-back commands:
  - cmd_ready is high in the cycle after the done pulse.
  - The minimum command-to-command gap is 1 idle cycle.
- Protocol constraint: mem_req, once asserted, holds mem_addr/mem_we/mem_wdata stable until it is granted.

Test Plan:
- Load, addr=0x100, len=3, gnt always 1, rvalid 2 cycles after grant, data 0xA1,0xA2,0xA3 → reads issued at 0x100–0x102; din_valid high 3 cycles carrying 0xA1,0xA2,0xA3, each 1 cycle after its rvalid; done pulse 1 cycle after the last din; busy low the next cycle.
- Load, len=8, MAX_OUTSTANDING=4, rvalid delayed 10 cycles → mem_req drops after 4 grants and resumes as returns arrive; 8 din words delivered in order.
- Store, addr=0x20, len=4, engine dout words 0x11..0x14, mem_gnt alternating 0/1 → writes 0x11..0x14 to 0x20..0x23; dout_ready never accepts a 5th word; one done pulse.
- cmd_len=0 in both modes → no mem_req, no din_valid, no dout_ready; done pulse 1 cycle after acceptance.
- Assert rst for 1 cycle during a load with 2 reads outstanding, then let the 2 late rvalids arrive → all outputs at reset values; late rvalids produce no din_valid; cmd_ready=1.
- Load at addr=0xFFFFFFFF, len=2 → mem_addr sequence 0xFFFFFFFF then 0x00000000.
